// File: rtl/register_read_bank.sv
// Indexed read of a flat register bus (live or snapshot) with RD_LATENCY-cycle latency to a one-cycle done.
// Backpressure: busy is high while a read is in flight; rd seen while busy is dropped, not queued.
module register_read_bank #(
  parameter int DATA_W       = 32,
  parameter int NUM_REGS     = 4,
  parameter int RD_LATENCY   = 1,
  parameter int USE_SNAPSHOT = 0,
  localparam int ADDR_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       rd,
  input  logic [ADDR_W-1:0]          rd_addr,
  input  logic [NUM_REGS*DATA_W-1:0] reg_in,
  input  logic                       snap,
  output logic [DATA_W-1:0]          rd_data,
  output logic                       done,
  output logic                       err,
  output logic                       busy
);

  localparam int CNT_W = 3;

  logic [DATA_W-1:0] src_words [NUM_REGS];
  logic [DATA_W-1:0] word_sel;
  logic              addr_oor;
  logic              accept;
  logic              complete;
  logic [DATA_W-1:0] cmp_data;
  logic              cmp_err;

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] pend_data_q, pend_data_d;
  logic              pend_err_q, pend_err_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  generate
    if (USE_SNAPSHOT != 0) begin : g_snap
      logic [DATA_W-1:0] snap_q [NUM_REGS];

      // Registered bank: a read sampled on the same edge as snap sees the old copy.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < NUM_REGS; i++) snap_q[i] <= '0;
        end else if (snap) begin
          for (int i = 0; i < NUM_REGS; i++) snap_q[i] <= reg_in[i*DATA_W +: DATA_W];
        end
      end

      always_comb begin
        for (int i = 0; i < NUM_REGS; i++) src_words[i] = snap_q[i];
      end
    end else begin : g_live
      logic unused_snap;
      assign unused_snap = snap;

      always_comb begin
        for (int i = 0; i < NUM_REGS; i++) src_words[i] = reg_in[i*DATA_W +: DATA_W];
      end
    end
  endgenerate

  // Out-of-range addresses fall through the decode with zero data and the error flag set.
  always_comb begin
    word_sel = '0;
    addr_oor = 1'b1;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_addr == ADDR_W'(i)) begin
        word_sel = src_words[i];
        addr_oor = 1'b0;
      end
    end
  end

  assign busy   = (cnt_q != '0);
  assign accept = rd && !busy;

  always_comb begin
    cnt_d       = cnt_q;
    pend_data_d = pend_data_q;
    pend_err_d  = pend_err_q;
    complete    = 1'b0;
    cmp_data    = pend_data_q;
    cmp_err     = pend_err_q;

    if (RD_LATENCY == 1) begin
      complete = accept;
      cmp_data = word_sel;
      cmp_err  = addr_oor;
    end else begin
      if (cnt_q != '0) begin
        cnt_d    = cnt_q - 1'b1;
        complete = (cnt_q == CNT_W'(1));
      end
      if (accept) begin
        cnt_d       = CNT_W'(RD_LATENCY - 1);
        pend_data_d = word_sel;
        pend_err_d  = addr_oor;
      end
    end

    done_d    = complete;
    err_d     = complete && cmp_err;
    rd_data_d = complete ? cmp_data : rd_data_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      pend_data_q <= '0;
      pend_err_q  <= 1'b0;
      rd_data_q   <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      pend_data_q <= pend_data_d;
      pend_err_q  <= pend_err_d;
      rd_data_q   <= rd_data_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign rd_data = rd_data_q;
  assign done    = done_q;
  assign err     = err_q;

endmodule
